// File: rtl/npc_mem_pkg.sv
// Shared memory-access definitions for the NPC core: size encodings, default window base
// and the byte-strobe helper used by load/store units.
package npc_mem_pkg;

  typedef logic [1:0] mem_size_t;

  localparam mem_size_t SZ_B = 2'd0;
  localparam mem_size_t SZ_H = 2'd1;
  localparam mem_size_t SZ_W = 2'd2;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

  function automatic logic [3:0] byte_strobe(input mem_size_t size, input logic [1:0] lane);
    case (size)
      SZ_B:    byte_strobe = 4'b0001 << lane;
      SZ_H:    byte_strobe = 4'b0011 << lane;
      SZ_W:    byte_strobe = 4'b1111;
      default: byte_strobe = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response handshake between the core memory stage (master) and the LSU (slave).
interface dmem_lsu_if;
  import npc_mem_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  mem_size_t   req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dmem_ram.sv
// DEPTH x 32 single-port synchronous RAM, byte write enables, registered read (1 cycle).
// Kept separate so it can be replaced by a vendor macro.
module dmem_ram #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rd_en,
  input  logic [3:0]               we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
    if (rd_en) rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_lsu.sv
// Windowed data-memory LSU: sized stores with byte merge, sign/zero-extended loads, error check.
// Latency 1 with a one-entry response buffer; req_ready drops only while a response is held.
module dmem_lsu
  import npc_mem_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input logic       clk,
  input logic       rst_n,
  dmem_lsu_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state;
  logic [31:0]      off;
  logic [1:0]       lane;
  logic [IDX_W-1:0] idx;
  logic             in_range;
  logic             misaligned;
  logic             req_err;
  logic             accept;
  logic [3:0]       strobe;
  logic             rd_en;
  logic [31:0]      wdata_rep;
  logic [31:0]      word;
  logic             err_q;
  logic             load_q;
  logic             uns_q;
  logic [1:0]       lane_q;
  mem_size_t        size_q;
  logic [7:0]       sel_b;
  logic [15:0]      sel_h;
  logic [31:0]      fmt;

  // Shifting instead of comparing against DEPTH*4 keeps the range test overflow-free.
  assign off        = bus.req_addr - BASE_ADDR;
  assign lane       = off[1:0];
  assign idx        = off[IDX_W+1:2];
  assign in_range   = (off >> (IDX_W + 2)) == 32'd0;
  assign misaligned = (bus.req_size == SZ_H && lane[0]) || (bus.req_size == SZ_W && lane != 2'd0);
  assign req_err    = !in_range || misaligned || !(bus.req_size inside {SZ_B, SZ_H, SZ_W});

  assign bus.resp_valid = (state == FULL);
  assign bus.req_ready  = (state == EMPTY) || bus.resp_ready;
  assign accept         = bus.req_valid && bus.req_ready;

  assign strobe = (accept && bus.req_we && !req_err) ? byte_strobe(bus.req_size, lane) : 4'b0000;
  assign rd_en  = accept && !bus.req_we && !req_err;

  always_comb begin
    wdata_rep = bus.req_wdata;
    case (bus.req_size)
      SZ_B:    wdata_rep = {4{bus.req_wdata[7:0]}};
      SZ_H:    wdata_rep = {2{bus.req_wdata[15:0]}};
      default: wdata_rep = bus.req_wdata;
    endcase
  end

  dmem_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .rd_en (rd_en),
    .we    (strobe),
    .idx   (idx),
    .wdata (wdata_rep),
    .rdata (word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      err_q  <= 1'b0;
      load_q <= 1'b0;
      uns_q  <= 1'b0;
      lane_q <= 2'd0;
      size_q <= SZ_B;
    end else if (accept) begin
      state  <= FULL;
      err_q  <= req_err;
      load_q <= !bus.req_we;
      uns_q  <= bus.req_unsigned;
      lane_q <= lane;
      size_q <= bus.req_size;
    end else if (bus.resp_ready) begin
      state  <= EMPTY;
    end
  end

  assign sel_b = word[{lane_q, 3'b000} +: 8];
  assign sel_h = lane_q[1] ? word[31:16] : word[15:0];

  always_comb begin
    fmt = word;
    case (size_q)
      SZ_B:    fmt = uns_q ? {24'd0, sel_b} : {{24{sel_b[7]}}, sel_b};
      SZ_H:    fmt = uns_q ? {16'd0, sel_h} : {{16{sel_h[15]}}, sel_h};
      default: fmt = word;
    endcase
  end

  // Stores, errors and an empty buffer all present zero data.
  assign bus.resp_rdata = (state == FULL && load_q && !err_q) ? fmt : 32'd0;
  assign bus.resp_err   = (state == FULL) && err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with an in-order response scoreboard.
module tb_dmem_lsu;
  import npc_mem_pkg::*;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   n_resp = 0;
  int   n0;
  exp_t sb[$];

  dmem_lsu_if bus();

  dmem_lsu #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sval(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h0000_0101;
  endfunction

  // Responses are taken at the edge following a negedge where valid && ready.
  always @(negedge clk) begin
    if (rst_n && bus.resp_valid && bus.resp_ready) begin
      if (sb.size() == 0) begin
        chk("resp_unexpected", 32'(bus.resp_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_rdata", bus.resp_rdata, e.rdata);
        chk("resp_err", 32'(bus.resp_err), 32'(e.err));
        n_resp++;
      end
    end
  end

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic issue(input logic we, input mem_size_t sz, input logic uns, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err);
    int n;
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    sb.push_back('{rdata: exp_rd, err: exp_err});
    @(negedge clk);
    n = 0;
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("req_ready_timeout", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = SZ_W;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = BASE;
    bus.req_wdata    = 32'd0;
    bus.resp_ready   = 1'b1;

    // 1. Reset and word access
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_req_ready", 32'(bus.req_ready), 32'd1);
    issue(1'b1, SZ_W, 1'b0, BASE + 32'h10, 32'hDEAD_BEEF, 32'd0, 1'b0);
    issue(1'b0, SZ_W, 1'b0, BASE + 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0);
    chk("lat1_valid", 32'(bus.resp_valid), 32'd1);
    chk("lat1_rdata", bus.resp_rdata, 32'hDEAD_BEEF);

    // 2. Byte merge and extension
    issue(1'b1, SZ_B, 1'b0, BASE + 32'h13, 32'h0000_0080, 32'd0, 1'b0);
    issue(1'b0, SZ_W, 1'b0, BASE + 32'h10, 32'd0, 32'h80AD_BEEF, 1'b0);
    issue(1'b0, SZ_B, 1'b0, BASE + 32'h13, 32'd0, 32'hFFFF_FF80, 1'b0);
    issue(1'b0, SZ_B, 1'b1, BASE + 32'h13, 32'd0, 32'h0000_0080, 1'b0);
    issue(1'b0, SZ_H, 1'b0, BASE + 32'h12, 32'd0, 32'hFFFF_80AD, 1'b0);
    issue(1'b0, SZ_H, 1'b1, BASE + 32'h10, 32'd0, 32'h0000_BEEF, 1'b0);

    // 3. Errors
    issue(1'b0, SZ_H, 1'b0, BASE + 32'h11, 32'd0, 32'd0, 1'b1);
    issue(1'b1, SZ_W, 1'b0, BASE + 32'hFFC, 32'h1122_3344, 32'd0, 1'b0);
    issue(1'b1, SZ_W, 1'b0, BASE + 32'hFFE, 32'hFFFF_FFFF, 32'd0, 1'b1);
    issue(1'b0, SZ_W, 1'b0, BASE + 32'hFFC, 32'd0, 32'h1122_3344, 1'b0);
    issue(1'b0, SZ_W, 1'b0, 32'h7FFF_FFFC, 32'd0, 32'd0, 1'b1);
    issue(1'b0, SZ_W, 1'b0, BASE + DEPTH * 4, 32'd0, 32'd0, 1'b1);
    issue(1'b0, 2'd3, 1'b0, BASE + 32'h10, 32'd0, 32'd0, 1'b1);
    issue(1'b1, 2'd3, 1'b0, BASE + 32'h10, 32'hFFFF_FFFF, 32'd0, 1'b1);
    issue(1'b0, SZ_W, 1'b0, BASE + 32'h10, 32'd0, 32'h80AD_BEEF, 1'b0);
    drain();

    // 4. Backpressure with a queued request
    issue(1'b1, SZ_W, 1'b0, BASE + 32'h20, 32'h1234_5678, 32'd0, 1'b0);
    issue(1'b0, SZ_W, 1'b0, BASE + 32'h20, 32'd0, 32'h1234_5678, 1'b0);
    bus.resp_ready   = 1'b0;
    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b0;
    bus.req_size     = SZ_W;
    bus.req_addr     = BASE + 32'h10;
    sb.push_back('{rdata: 32'h80AD_BEEF, err: 1'b0});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(bus.resp_valid), 32'd1);
      chk("stall_rdata", bus.resp_rdata, 32'h1234_5678);
      chk("stall_err", 32'(bus.resp_err), 32'd0);
      chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("queued_valid", 32'(bus.resp_valid), 32'd1);
    chk("queued_rdata", bus.resp_rdata, 32'h80AD_BEEF);
    drain();

    // 5. Streaming: one response per cycle
    n0 = n_resp;
    for (int i = 0; i < 8; i++) issue(1'b1, SZ_W, 1'b0, BASE + 32'(4 * i), sval(i), 32'd0, 1'b0);
    for (int i = 0; i < 8; i++) issue(1'b0, SZ_W, 1'b0, BASE + 32'(4 * i), 32'd0, sval(i), 1'b0);
    chk("stream_rate", 32'(n_resp - n0), 32'd15);
    drain();
    chk("stream_total", 32'(n_resp - n0), 32'd16);

    // 6. Asynchronous reset while a response is held
    bus.resp_ready = 1'b0;
    issue(1'b0, SZ_W, 1'b0, BASE + 32'h4, 32'd0, sval(1), 1'b0);
    chk("pre_rst_valid", 32'(bus.resp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.resp_valid), 32'd0);
    sb.delete(sb.size() - 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(bus.resp_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    issue(1'b0, SZ_W, 1'b0, BASE + 32'h1C, 32'd0, sval(7), 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
